// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues req/ack data-memory accesses, stalls upstream while busy,
// and registers the MEM/WB boundary. Optional macro MEM_ALIGN_CHECK_EN adds misaligned-access trapping.
module mem_stage_ctrl #(
    parameter int ADDR_W = 30
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
`ifdef MEM_ALIGN_CHECK_EN
    output logic              o_misaligned,
`endif
    input  logic              i_RegWrite,
    input  logic              i_MemtoReg,
    input  logic              i_MemWrite,
    input  logic              i_MemRead,
    input  logic [31:0]       i_ALUresult,
    input  logic [31:0]       i_writedata,
    input  logic [4:0]        i_writeReg,
    output logic              o_stall,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [31:0]       o_dmem_wdata,
    input  logic              i_dmem_ack,
    input  logic [31:0]       i_dmem_rdata,
    output logic              o_RegWriteOut,
    output logic              o_MemtoRegOut,
    output logic [31:0]       o_ALUresultOut,
    output logic [31:0]       o_readdataOut,
    output logic [4:0]        o_writeRegOut
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_dmem_req;
    logic                r_dmem_we;
    logic [ADDR_W-1:0]   r_dmem_addr;
    logic [31:0]         r_dmem_wdata;
    logic                r_RegWrite;
    logic                r_MemtoReg;
    logic [31:0]         r_ALUresult;
    logic [31:0]         r_readdata;
    logic [4:0]          r_writeReg;

    logic w_mem_op;
    logic w_issue;
    logic w_stall;

    assign w_mem_op = i_MemRead | i_MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
    logic w_misalign;
    logic r_misaligned;
    assign w_misalign   = w_mem_op & (|i_ALUresult[1:0]);
    assign w_issue      = w_mem_op & ~w_misalign;
    assign o_misaligned = r_misaligned;
`else
    logic w_unused_lo_bits;
    assign w_unused_lo_bits = ^i_ALUresult[1:0];
    assign w_issue          = w_mem_op;
`endif

    // Stall is forced low while reset is asserted, even with a memory op presented.
    always_comb begin
        w_stall = 1'b0;
        if (i_rst_n) begin
            case (r_state)
                IDLE:    w_stall = w_issue;
                ACCESS:  w_stall = ~i_dmem_ack;
                default: w_stall = 1'b0;
            endcase
        end
    end

    assign o_stall = w_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_RegWrite   <= 1'b0;
            r_MemtoReg   <= 1'b0;
            r_ALUresult  <= '0;
            r_readdata   <= '0;
            r_writeReg   <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            r_misaligned <= 1'b0;
`endif
        end else begin
`ifdef MEM_ALIGN_CHECK_EN
            r_misaligned <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_state      <= ACCESS;
                        r_dmem_req   <= 1'b1;
                        // A load that is also flagged as a store wins; the write is dropped.
                        r_dmem_we    <= i_MemWrite & ~i_MemRead;
                        r_dmem_addr  <= i_ALUresult[ADDR_W+1:2];
                        r_dmem_wdata <= i_writedata;
                        r_RegWrite   <= 1'b0;
                        r_MemtoReg   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                    end else if (w_misalign) begin
                        r_RegWrite   <= 1'b0;
                        r_MemtoReg   <= 1'b0;
                        r_misaligned <= 1'b1;
`endif
                    end else begin
                        r_RegWrite   <= i_RegWrite;
                        r_MemtoReg   <= i_MemtoReg;
                        r_ALUresult  <= i_ALUresult;
                        r_writeReg   <= i_writeReg;
                    end
                end
                ACCESS: begin
                    if (i_dmem_ack) begin
                        r_state     <= IDLE;
                        r_dmem_req  <= 1'b0;
                        r_RegWrite  <= i_RegWrite;
                        r_MemtoReg  <= i_MemtoReg;
                        r_ALUresult <= i_ALUresult;
                        r_writeReg  <= i_writeReg;
                        if (!r_dmem_we) begin
                            r_readdata <= i_dmem_rdata;
                        end
                    end else begin
                        r_RegWrite  <= 1'b0;
                        r_MemtoReg  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_dmem_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_dmem_req     = r_dmem_req;
    assign o_dmem_we      = r_dmem_we;
    assign o_dmem_addr    = r_dmem_addr;
    assign o_dmem_wdata   = r_dmem_wdata;
    assign o_RegWriteOut  = r_RegWrite;
    assign o_MemtoRegOut  = r_MemtoReg;
    assign o_ALUresultOut = r_ALUresult;
    assign o_readdataOut  = r_readdata;
    assign o_writeRegOut  = r_writeReg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed + randomized bench for mem_stage_ctrl against an instruction-level reference model.
module tb_mem_stage_ctrl;

  localparam int ADDR_W = 30;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              reg_write, mem_to_reg, mem_write, mem_read;
  logic [31:0]       alu_result, write_data;
  logic [4:0]        write_reg;
  logic              stall, dmem_req, dmem_we, dmem_ack;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata, dmem_rdata;
  logic              rw_out, mtr_out;
  logic [31:0]       alu_out, rd_out;
  logic [4:0]        wreg_out;
`ifdef MEM_ALIGN_CHECK_EN
  logic              misaligned;
`endif

  mem_stage_ctrl #(.ADDR_W(ADDR_W)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
`ifdef MEM_ALIGN_CHECK_EN
    .o_misaligned   (misaligned),
`endif
    .i_RegWrite     (reg_write),
    .i_MemtoReg     (mem_to_reg),
    .i_MemWrite     (mem_write),
    .i_MemRead      (mem_read),
    .i_ALUresult    (alu_result),
    .i_writedata    (write_data),
    .i_writeReg     (write_reg),
    .o_stall        (stall),
    .o_dmem_req     (dmem_req),
    .o_dmem_we      (dmem_we),
    .o_dmem_addr    (dmem_addr),
    .o_dmem_wdata   (dmem_wdata),
    .i_dmem_ack     (dmem_ack),
    .i_dmem_rdata   (dmem_rdata),
    .o_RegWriteOut  (rw_out),
    .o_MemtoRegOut  (mtr_out),
    .o_ALUresultOut (alu_out),
    .o_readdataOut  (rd_out),
    .o_writeRegOut  (wreg_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model of the MEM/WB boundary
  logic        m_rw, m_mtr;
  logic [31:0] m_alu, m_rd;
  logic [4:0]  m_wreg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_rw = 1'b0; m_mtr = 1'b0; m_alu = '0; m_rd = '0; m_wreg = '0;
  endtask

  task automatic check_wb(input string tag);
    check({tag, "_rw"},   {31'b0, rw_out},   {31'b0, m_rw});
    check({tag, "_mtr"},  {31'b0, mtr_out},  {31'b0, m_mtr});
    check({tag, "_alu"},  alu_out,           m_alu);
    check({tag, "_rd"},   rd_out,            m_rd);
    check({tag, "_wreg"}, {27'b0, wreg_out}, {27'b0, m_wreg});
  endtask

  task automatic drive_idle_inputs();
    reg_write = 0; mem_to_reg = 0; mem_write = 0; mem_read = 0;
    alu_result = '0; write_data = '0; write_reg = '0;
    dmem_ack = 0; dmem_rdata = '0;
  endtask

  // One instruction through the MEM stage; the memory responds after 'waits' extra cycles.
  task automatic run_op(input logic rw, input logic mtr, input logic mw, input logic mr,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wreg,
                        input int waits, input logic [31:0] rdata);
    logic        is_mem, misal, exp_we;
    logic [31:0] exp_addr;
    int          stall_cnt, req_cnt;
    reg_write = rw; mem_to_reg = mtr; mem_write = mw; mem_read = mr;
    alu_result = alu; write_data = wd; write_reg = wreg;
    dmem_ack = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    is_mem   = mw | mr;
    exp_we   = mw & ~mr;
    exp_addr = {2'b00, alu[31:2]};
    misal    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misal = is_mem && (alu[1:0] != 2'b00);
`endif
    #1;
    check("idle_req", {31'b0, dmem_req}, 32'd0);
    if (!is_mem || misal) begin
      check("idle_stall", {31'b0, stall}, 32'd0);
      tick();
      dmem_ack = 0;
      if (misal) begin
        m_rw = 1'b0; m_mtr = 1'b0;
      end else begin
        m_rw = rw; m_mtr = mtr; m_alu = alu; m_wreg = wreg;
      end
      check_wb("nomem");
      check("nomem_req", {31'b0, dmem_req}, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
      check("misaligned", {31'b0, misaligned}, {31'b0, misal});
      tick();
      check("misaligned_clear", {31'b0, misaligned}, 32'd0);
`endif
    end else begin
      stall_cnt = 0;
      req_cnt = 0;
      if (stall) stall_cnt++;
      tick();
      dmem_ack = 0;
      m_rw = 1'b0; m_mtr = 1'b0;
      check_wb("issue");
      for (int k = 0; k < waits; k++) begin
        #1;
        if (stall) stall_cnt++;
        if (dmem_req) req_cnt++;
        check("wait_we",    {31'b0, dmem_we}, {31'b0, exp_we});
        check("wait_addr",  {2'b00, dmem_addr}, exp_addr);
        check("wait_wdata", dmem_wdata, wd);
        tick();
        check_wb("wait");
      end
      dmem_ack = 1;
      dmem_rdata = rdata;
      #1;
      if (stall) stall_cnt++;
      if (dmem_req) req_cnt++;
      check("ack_stall", {31'b0, stall}, 32'd0);
      check("ack_we",    {31'b0, dmem_we}, {31'b0, exp_we});
      check("ack_addr",  {2'b00, dmem_addr}, exp_addr);
      check("ack_wdata", dmem_wdata, wd);
      tick();
      dmem_ack = 0;
      m_rw = rw; m_mtr = mtr; m_alu = alu; m_wreg = wreg;
      if (mr) m_rd = rdata;
      check_wb("done");
      check("done_req",   {31'b0, dmem_req}, 32'd0);
      check("stall_cycles", stall_cnt, waits + 1);
      check("req_cycles",   req_cnt,   waits + 1);
`ifdef MEM_ALIGN_CHECK_EN
      check("mem_misaligned", {31'b0, misaligned}, 32'd0);
`endif
    end
  endtask

  initial begin
    drive_idle_inputs();
    model_reset();
    mem_read = 1;
    #12;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_req",   {31'b0, dmem_req}, 32'd0);
    check_wb("rst");
    mem_read = 0;
    rst_n = 1;
    tick();

    // ALU op: 0x10 -> r5
    run_op(1, 0, 0, 0, 32'h0000_0010, 32'h0, 5'd5, 0, 32'h0);
    // Load 0x40 with 3 wait cycles
    run_op(1, 1, 0, 1, 32'h0000_0040, 32'h0, 5'd7, 3, 32'hDEAD_BEEF);
    // Store to 0x8 with immediate ack
    run_op(0, 0, 1, 0, 32'h0000_0008, 32'h1234_5678, 5'd0, 0, 32'hCAFE_F00D);
    // Load then store back to back
    run_op(1, 1, 0, 1, 32'h0000_0100, 32'h0, 5'd9, 0, 32'hA5A5_0001);
    run_op(0, 0, 1, 1 - 1, 32'h0000_0104, 32'h5A5A_0002, 5'd0, 0, 32'hFFFF_FFFF);
    // Load+store both set: treated as a read
    run_op(1, 1, 1, 1, 32'h0000_0200, 32'h7777_7777, 5'd3, 1, 32'h0BAD_CAFE);
`ifdef MEM_ALIGN_CHECK_EN
    run_op(1, 1, 0, 1, 32'h0000_0042, 32'h0, 5'd4, 0, 32'h0);
`endif

    // Reset in the middle of an access, then a late ack
    reg_write = 1; mem_to_reg = 1; mem_read = 1; alu_result = 32'h80; write_reg = 5'd2;
    tick();
    check("pre_rst_req", {31'b0, dmem_req}, 32'd1);
    rst_n = 0;
    #1;
    model_reset();
    check("mid_rst_req",   {31'b0, dmem_req}, 32'd0);
    check("mid_rst_stall", {31'b0, stall}, 32'd0);
    check("mid_rst_addr",  {2'b00, dmem_addr}, 32'd0);
    check("mid_rst_we",    {31'b0, dmem_we}, 32'd0);
    check("mid_rst_wdata", dmem_wdata, 32'd0);
    check_wb("mid_rst");
    drive_idle_inputs();
    #2;
    rst_n = 1;
    tick();
    dmem_ack = 1;
    dmem_rdata = 32'h1111_2222;
    #1;
    check("late_ack_stall", {31'b0, stall}, 32'd0);
    tick();
    dmem_ack = 0;
    check("late_ack_req", {31'b0, dmem_req}, 32'd0);
    check_wb("late_ack");

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
`endif
      case (kind)
        0: run_op(1'($urandom_range(0, 1)), 0, 0, 0, a, $urandom, 5'($urandom), 0, 32'h0);
        1: run_op(1, 1, 0, 1, a, $urandom, 5'($urandom), $urandom_range(0, 3), $urandom);
        2: run_op(0, 0, 1, 0, a, $urandom, 5'($urandom), $urandom_range(0, 3), $urandom);
        default: run_op(1, 1, 1, 1, a, $urandom, 5'($urandom), $urandom_range(0, 3), $urandom);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
